wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back end of the MEM/WB pipeline register.
- Consumes the MEM/WB outputs and selects the write-back value among ALU result, load data, PC+4 and PC-relative add.
- Commits that value to a 32x32 integer register file and serves the decode stage's two read ports, with same-cycle write-to-read bypass.
- Also keeps a 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, data width of registers and write-back sources.
- NREGS, 32, number of architectural registers; x0 hardwired zero.
- AW, 5, register address width (log2 NREGS).
- CNT_W, 64, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- valid_in  in  1  MEM/WB slot holds a real (non-bubble) instruction.
- reg_file_write_in  in  1  write-enable from MEM/WB.
- addr_rd_in  in  AW  destination register from MEM/WB.
- select_mux_2_in  in  2  write-back source select from MEM/WB.
- alu_result_in  in  XLEN  ALU result from MEM/WB.
- mem_in  in  XLEN  load data from MEM/WB.
- add_pc_in  in  XLEN  PC+4 from MEM/WB (link value).
- add_in  in  XLEN  PC+imm from MEM/WB (auipc/branch target).
- addr_rs1  in  AW  decode read address 1.
- addr_rs2  in  AW  decode read address 2.
- rs1_data  out  XLEN  read data 1 (combinational).
- rs2_data  out  XLEN  read data 2 (combinational).
- wb_data_out  out  XLEN  selected write-back value (combinational, for forwarding).
- wb_we_out  out  1  effective write strobe this cycle (combinational).
- instret_out  out  CNT_W  retired-instruction count (registered).

Behaviour:
- Source select (combinational): 2'b00 alu_result_in; 2'b01 mem_in; 2'b10 add_pc_in; 2'b11 add_in.
- wb_we_out = valid_in & reg_file_write_in & (addr_rd_in != 0) & ~reset.
- Write: on rising clk with wb_we_out=1, regs[addr_rd_in] <= wb_data_out. Latency 1 cycle to array; 0 cycles to readers via bypass.
- Writes to x0 are discarded. regs[0] is never stored; reads of x0 always return 0, including during a bypass attempt to rd=0.
- Read port N (N = 1, 2):
  - addr_rsN == 0 -> 0.
  - Else if wb_we_out & (addr_rd_in == addr_rsN) -> wb_data_out (bypass).
  - Else -> regs[addr_rsN].
- Both ports may hit the same address, and the same bypass, simultaneously; both return identical data.
- valid_in=0 (bubble): no write and no count, regardless of reg_file_write_in.
- instret_out: increments by 1 on rising clk when valid_in=1 and reset=0. Wraps from 2^64-1 to 0 with no flag.
- Reset (synchronous):
  - On the rising edge with reset=1, every register x1..x31 <= 0 and instret_out <= 0.
  - Any write presented in that cycle is dropped and not counted.
  - While reset is high, bypass is suppressed (wb_we_out=0), so reads return the array contents.
  - Reset asserted mid-operation behaves identically: the pending write is lost.
- No X propagation: any unknown select is a verification failure; RTL uses a full case with a default of alu_result_in.
- All outputs after the first reset edge: rs1_data=rs2_data=0 for every address, instret_out=0, wb_we_out=0.

Decomposition:
- Shared package (pipeline_pkg):
  - WB_SEL_ALU=2'b00, WB_SEL_MEM=2'b01, WB_SEL_PC4=2'b10, WB_SEL_ADD=2'b11.
  - XLEN, AW, REG_ZERO=5'd0.
- One sub-module, wb_mux: pure 4:1 XLEN-wide select keyed on the package constants. It is reused by the forwarding unit.
- Register array, bypass and counter stay in wb_regfile.

Test Plan:
- Reset then read all 32 addresses on both ports -> every rs*_data=0, instret_out=0.
- valid=1, we=1, rd=5, sel=00, alu=0xDEADBEEF, rs1=5 in the same cycle -> rs1_data=0xDEADBEEF via bypass. Next cycle with we=0 -> rs1_data=0xDEADBEEF from the array. instret_out=1.
- Sweep sel 01/10/11 writing rd=7 with mem=0x11, add_pc=0x104, add=0x2000 -> x7 reads 0x11, then 0x104, then 0x2000. wb_data_out matches each cycle.
- we=1, rd=0, alu=0xFFFFFFFF, rs1=rs2=0 -> both read 0, wb_we_out=0. x0 still reads 0 next cycle.
- Bubble: valid=0, we=1, rd=9, alu=0x55 -> x9 unchanged (0), instret_out unchanged.
- Reset mid-stream: write x3=0xA5 with reset=1 the same edge -> x3=0, instret_out=0. Force instret_out to 2^64-1 and retire one -> instret_out=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath widths, register file geometry and
// the write-back source select encoding used by the write-back mux and the
// forwarding unit.
package pipeline_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 64;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;
  localparam logic [1:0] WB_SEL_ADD = 2'b11;

  localparam logic [AW-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_mux.sv
// Write-back source select: pure 4:1 mux keyed on the WB_SEL_* encoding.
// Shared with the forwarding unit so both agree on the selected value.
// Ports:
//   sel       - write-back source select (WB_SEL_*)
//   alu_data  - ALU result
//   mem_data  - load data
//   pc4_data  - PC+4 link value
//   add_data  - PC+imm value
//   data_out  - selected value
module wb_mux
  import pipeline_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] alu_data,
  input  logic [W-1:0] mem_data,
  input  logic [W-1:0] pc4_data,
  input  logic [W-1:0] add_data,
  output logic [W-1:0] data_out
);

  // Source select; an unknown select falls back to the ALU result.
  always_comb begin
    data_out = alu_data;
    case (sel)
      WB_SEL_ALU: data_out = alu_data;
      WB_SEL_MEM: data_out = mem_data;
      WB_SEL_PC4: data_out = pc4_data;
      WB_SEL_ADD: data_out = add_data;
      default:    data_out = alu_data;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the write-back value from the MEM/WB register,
// commits it to the integer register file, serves the two decode read ports
// with same-cycle write-to-read bypass and counts retired instructions.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   valid_in             - MEM/WB slot holds a real instruction
//   reg_file_write_in    - write enable from MEM/WB
//   addr_rd_in           - destination register
//   select_mux_2_in      - write-back source select
//   alu_result_in, mem_in, add_pc_in, add_in - write-back sources
//   addr_rs1, addr_rs2   - decode read addresses
//   rs1_data, rs2_data   - read data (combinational, bypassed)
//   wb_data_out          - selected write-back value (combinational)
//   wb_we_out            - effective write strobe (combinational)
//   instret_out          - retired-instruction count (registered)
module wb_regfile
  import pipeline_pkg::*;
#(
  parameter int XLEN  = pipeline_pkg::XLEN,
  parameter int NREGS = pipeline_pkg::NREGS,
  parameter int AW    = pipeline_pkg::AW,
  parameter int CNT_W = pipeline_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             reg_file_write_in,
  input  logic [AW-1:0]    addr_rd_in,
  input  logic [1:0]       select_mux_2_in,
  input  logic [XLEN-1:0]  alu_result_in,
  input  logic [XLEN-1:0]  mem_in,
  input  logic [XLEN-1:0]  add_pc_in,
  input  logic [XLEN-1:0]  add_in,
  input  logic [AW-1:0]    addr_rs1,
  input  logic [AW-1:0]    addr_rs2,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic [XLEN-1:0]  wb_data_out,
  output logic             wb_we_out,
  output logic [CNT_W-1:0] instret_out
);

  // x0 is never stored, so the array starts at x1.
  logic [XLEN-1:0]  regs_r [1:NREGS-1];
  logic [CNT_W-1:0] instret_r;
  logic [XLEN-1:0]  wb_data_s;
  logic             wb_we_s;

  wb_mux #(.W(XLEN)) u_wb_mux (
    .sel      (select_mux_2_in),
    .alu_data (alu_result_in),
    .mem_data (mem_in),
    .pc4_data (add_pc_in),
    .add_data (add_in),
    .data_out (wb_data_s)
  );

  // Reset suppresses the strobe so the bypass never exposes a dropped write.
  assign wb_we_s = valid_in & reg_file_write_in & (addr_rd_in != {AW{1'b0}}) & ~reset;

  assign wb_data_out = wb_data_s;
  assign wb_we_out   = wb_we_s;
  assign instret_out = instret_r;

  // Read port 1: x0 forced to zero, then bypass, then array.
  always_comb begin
    rs1_data = {XLEN{1'b0}};
    if (addr_rs1 == {AW{1'b0}}) begin
      rs1_data = {XLEN{1'b0}};
    end else if (wb_we_s && (addr_rd_in == addr_rs1)) begin
      rs1_data = wb_data_s;
    end else begin
      rs1_data = regs_r[addr_rs1];
    end
  end

  // Read port 2: identical priority to port 1.
  always_comb begin
    rs2_data = {XLEN{1'b0}};
    if (addr_rs2 == {AW{1'b0}}) begin
      rs2_data = {XLEN{1'b0}};
    end else if (wb_we_s && (addr_rd_in == addr_rs2)) begin
      rs2_data = wb_data_s;
    end else begin
      rs2_data = regs_r[addr_rs2];
    end
  end

  // Register array commit and retired-instruction counter (wraps silently).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
      instret_r <= {CNT_W{1'b0}};
    end else begin
      if (wb_we_s) begin
        regs_r[addr_rd_in] <= wb_data_s;
      end
      if (valid_in) begin
        instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: the driver issues one MEM/WB slot per cycle
// and pushes the expected outputs computed by a plain array/counter model;
// a separate monitor pops and compares on the falling edge. A second instance
// with a 4-bit counter exercises counter wrap-around.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic        reg_file_write_in = 1'b0;
  logic [4:0]  addr_rd_in = 5'd0;
  logic [1:0]  select_mux_2_in = 2'b00;
  logic [31:0] alu_result_in = 32'd0;
  logic [31:0] mem_in = 32'd0;
  logic [31:0] add_pc_in = 32'd0;
  logic [31:0] add_in = 32'd0;
  logic [4:0]  addr_rs1 = 5'd0;
  logic [4:0]  addr_rs2 = 5'd0;

  logic [31:0] rs1_data, rs2_data, wb_data_out;
  logic        wb_we_out;
  logic [63:0] instret_out;

  logic [31:0] s_rs1_data, s_rs2_data, s_wb_data_out;
  logic        s_wb_we_out;
  logic [3:0]  s_instret_out;

  wb_regfile dut (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .reg_file_write_in(reg_file_write_in), .addr_rd_in(addr_rd_in),
    .select_mux_2_in(select_mux_2_in), .alu_result_in(alu_result_in),
    .mem_in(mem_in), .add_pc_in(add_pc_in), .add_in(add_in),
    .addr_rs1(addr_rs1), .addr_rs2(addr_rs2),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_data_out(wb_data_out),
    .wb_we_out(wb_we_out), .instret_out(instret_out)
  );

  wb_regfile #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .reg_file_write_in(reg_file_write_in), .addr_rd_in(addr_rd_in),
    .select_mux_2_in(select_mux_2_in), .alu_result_in(alu_result_in),
    .mem_in(mem_in), .add_pc_in(add_pc_in), .add_in(add_in),
    .addr_rs1(addr_rs1), .addr_rs2(addr_rs2),
    .rs1_data(s_rs1_data), .rs2_data(s_rs2_data), .wb_data_out(s_wb_data_out),
    .wb_we_out(s_wb_we_out), .instret_out(s_instret_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] wb;
    logic        we;
    logic [63:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  bit          done = 1'b0;

  // Reference model state: architectural registers and retired count.
  logic [31:0] m_regs [0:31];
  logic [63:0] m_cnt;
  int          wraps_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are always presented, so one expectation per cycle.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.chk) begin
        check("rs1_data", {32'd0, rs1_data}, {32'd0, e.rs1});
        check("rs2_data", {32'd0, rs2_data}, {32'd0, e.rs2});
        check("wb_data_out", {32'd0, wb_data_out}, {32'd0, e.wb});
        check("wb_we_out", {63'd0, wb_we_out}, {63'd0, e.we});
        check("instret_out", instret_out, e.cnt);
        check("small_rs1", {32'd0, s_rs1_data}, {32'd0, e.rs1});
        check("small_instret", {60'd0, s_instret_out}, {60'd0, e.cnt[3:0]});
      end
    end
  end

  // Issue one slot after the rising edge and record what the DUT must show.
  task automatic step(input bit rst, input bit v, input bit w, input logic [4:0] rd,
                      input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] mem,
                      input logic [31:0] pc4, input logic [31:0] add,
                      input logic [4:0] r1, input logic [4:0] r2, input bit chk);
    exp_t        e;
    logic [31:0] srcs [0:3];
    logic [31:0] wbv;
    bit          we;
    @(posedge clk);
    #1;
    reset = rst; valid_in = v; reg_file_write_in = w; addr_rd_in = rd;
    select_mux_2_in = sel; alu_result_in = alu; mem_in = mem;
    add_pc_in = pc4; add_in = add; addr_rs1 = r1; addr_rs2 = r2;
    srcs[0] = alu; srcs[1] = mem; srcs[2] = pc4; srcs[3] = add;
    wbv = srcs[sel];
    we  = v && w && (rd != 5'd0) && !rst;
    e.chk = chk;
    e.wb  = wbv;
    e.we  = we;
    e.rs1 = (r1 == 5'd0) ? 32'd0 : ((we && rd == r1) ? wbv : m_regs[r1]);
    e.rs2 = (r2 == 5'd0) ? 32'd0 : ((we && rd == r2) ? wbv : m_regs[r2]);
    e.cnt = m_cnt;
    sb_q.push_back(e);
    // Effect of the coming edge on the model.
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_cnt = 64'd0;
    end else begin
      if (we) m_regs[rd] = wbv;
      if (v) begin
        m_cnt = m_cnt + 64'd1;
        if (m_cnt[3:0] == 4'd0) wraps_seen++;
      end
    end
  endtask

  task automatic idle_read(input logic [4:0] r1, input logic [4:0] r2);
    step(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, r1, r2, 1'b1);
  endtask

  task automatic finish_run();
    if (!done) begin
      done = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  endtask

  // Watchdog against a stalled run.
  initial begin
    #200000;
    total++;
    bad++;
    $display("FAIL watchdog actual=timeout expected=completion");
    finish_run();
  end

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_cnt = 64'd0;

    // First reset edge: array contents are unknown before it.
    step(1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 5'd1, 5'd2, 1'b0);
    step(1'b1, 1'b1, 1'b1, 5'd4, 2'b00, 32'h1234, 32'd0, 32'd0, 32'd0, 5'd4, 5'd4, 1'b1);
    for (int i = 0; i < 32; i++) idle_read(i[4:0], 5'(31 - i));

    // Bypass then array read of x5.
    step(1'b0, 1'b1, 1'b1, 5'd5, 2'b00, 32'hDEADBEEF, 32'd0, 32'd0, 32'd0, 5'd5, 5'd5, 1'b1);
    idle_read(5'd5, 5'd0);

    // Source sweep into x7.
    step(1'b0, 1'b1, 1'b1, 5'd7, 2'b01, 32'h1, 32'h11, 32'h104, 32'h2000, 5'd7, 5'd5, 1'b1);
    idle_read(5'd7, 5'd7);
    step(1'b0, 1'b1, 1'b1, 5'd7, 2'b10, 32'h1, 32'h11, 32'h104, 32'h2000, 5'd7, 5'd0, 1'b1);
    idle_read(5'd7, 5'd7);
    step(1'b0, 1'b1, 1'b1, 5'd7, 2'b11, 32'h1, 32'h11, 32'h104, 32'h2000, 5'd0, 5'd7, 1'b1);
    idle_read(5'd7, 5'd7);

    // Write to x0 is discarded, including through the bypass.
    step(1'b0, 1'b1, 1'b1, 5'd0, 2'b00, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1);
    idle_read(5'd0, 5'd0);

    // Bubble with write enable set.
    step(1'b0, 1'b0, 1'b1, 5'd9, 2'b00, 32'h55, 32'd0, 32'd0, 32'd0, 5'd9, 5'd9, 1'b1);
    idle_read(5'd9, 5'd9);

    // Reset on the same edge as a write to x3.
    step(1'b1, 1'b1, 1'b1, 5'd3, 2'b00, 32'hA5, 32'd0, 32'd0, 32'd0, 5'd3, 5'd7, 1'b1);
    idle_read(5'd3, 5'd7);

    // Randomized traffic, reads biased toward the destination register.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] rd, r1, r2;
      rd = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0), $urandom_range(0, 1) == 1,
           rd, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom, r1, r2, 1'b1);
    end

    // Run the narrow counter through a wrap after a clean reset.
    step(1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 5'd1, 5'd2, 1'b1);
    for (int n = 0; n < 20; n++) begin
      step(1'b0, 1'b1, 1'b0, 5'd1, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 5'd1, 5'd2, 1'b1);
    end
    idle_read(5'd1, 5'd2);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    check("counter_wrapped", 64'(wraps_seen > 0), 64'd1);
    finish_run();
  end

endmodule
